// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants, state encoding and default widths for the mux scan sequencer.
// Optional parity output: define MUX_SCAN_PARITY_EN.
package mux_scan_ctrl_pkg;

  localparam int URCPU_MUX_DATA_W = 20;
  localparam int URCPU_MUX_ADDR_W = 5;
  localparam int MSC_CNT_W        = 5;

  typedef enum logic [1:0] {
    MSC_IDLE = 2'd0,
    MSC_SCAN = 2'd1,
    MSC_DONE = 2'd2
  } msc_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word-in / result-out handshakes of the mux scan sequencer.
// Optional out_parity signal: define MUX_SCAN_PARITY_EN.
interface mux_scan_ctrl_if
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = URCPU_MUX_DATA_W,
  parameter int CNT_W  = MSC_CNT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_word;
  logic [CNT_W-1:0]  out_count;
  logic              out_mismatch;
`ifdef MUX_SCAN_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_word,
    input  out_count, out_mismatch
`ifdef MUX_SCAN_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_word,
    output out_count, out_mismatch
`ifdef MUX_SCAN_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Sweeps a mux address across a latched word and reassembles the sampled bits.
// Optional parity of sampled bits: define MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = URCPU_MUX_DATA_W,
  parameter int ADDR_W = URCPU_MUX_ADDR_W,
  parameter int CNT_W  = MSC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  mux_scan_ctrl_if.slave    bus,
  output logic [DATA_W-1:0] mux_data,
  output logic [ADDR_W-1:0] mux_addr,
  input  logic              mux_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_W - 1);

  msc_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mism_q, mism_d;
  logic              par_q, par_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MSC_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    mism_d  = mism_q;
    par_d   = par_q;
    unique case (state_q)
      MSC_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          addr_d  = '0;
          word_d  = '0;
          cnt_d   = '0;
          mism_d  = 1'b0;
          par_d   = 1'b0;
          state_d = MSC_SCAN;
        end
      end
      MSC_SCAN: begin
        word_d[addr_q] = mux_out;
        cnt_d = cnt_q + CNT_W'(mux_out);
        par_d = par_q ^ mux_out;
        // Compare against the word including the bit sampled this cycle
        if (addr_q == LAST) begin
          mism_d  = (word_d != data_q);
          state_d = MSC_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      MSC_DONE: begin
        if (bus.out_ready) state_d = MSC_IDLE;
      end
      default: state_d = MSC_IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == MSC_IDLE);
  assign bus.out_valid    = (state_q == MSC_DONE);
  assign bus.out_word     = word_q;
  assign bus.out_count    = cnt_q;
  assign bus.out_mismatch = mism_q;
  assign mux_data         = data_q;
  assign mux_addr         = addr_q;

`ifdef MUX_SCAN_PARITY_EN
  assign bus.out_parity = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 20:1 mux attached.
// Optional parity checks enabled by MUX_SCAN_PARITY_EN.
module tb_mux_scan_ctrl;
  import mux_scan_ctrl_pkg::*;

  localparam int DW = URCPU_MUX_DATA_W;
  localparam int AW = URCPU_MUX_ADDR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] mux_data;
  logic [AW-1:0] mux_addr;
  logic          mux_out;
  logic          flt_en;

  int checks = 0;
  int passed = 0;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mux_data (mux_data),
    .mux_addr (mux_addr),
    .mux_out  (mux_out)
  );

  always #5 clk = ~clk;

  // Reference mux, with a stuck-at-0 fault on address 3 when enabled
  always_comb begin
    mux_out = 1'b0;
    if (int'(mux_addr) < DW) mux_out = mux_data[mux_addr];
    if (flt_en && mux_addr == AW'(3)) mux_out = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("pop_valid", 32'(bus.out_valid), 32'd0);
    chk("pop_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [DW-1:0] w,
                           input logic [DW-1:0] ew, input int ec,
                           input logic em);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_word"}, 32'(bus.out_word), 32'(ew));
    chk({tag, "_cnt"}, 32'(bus.out_count), 32'(ec));
    chk({tag, "_mism"}, 32'(bus.out_mismatch), 32'(em));
    chk({tag, "_data"}, 32'(mux_data), 32'(w));
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, "_par"}, 32'(bus.out_parity), 32'(^ew));
`endif
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] hw;
    int lat;
    int n;
    int sd;
    rst = 1'b1;
    flt_en = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(mux_data), 32'd0);
    chk("rst_addr", 32'(mux_addr), 32'd0);
    chk("rst_word", 32'(bus.out_word), 32'd0);
    chk("rst_cnt", 32'(bus.out_count), 32'd0);
    chk("rst_mism", 32'(bus.out_mismatch), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_par", 32'(bus.out_parity), 32'd0);
`endif

    for (int i = 0; i < DW; i++) begin
      w = DW'(1) << i;
      send(w);
      wait_done(lat);
      chk("walk_lat", 32'(lat), 32'd21);
      check_res("walk", w, w, 1, 1'b0);
      pop();
    end

    send(20'hA5A5A);
    wait_done(lat);
    check_res("pat", 20'hA5A5A, 20'hA5A5A, 10, 1'b0);
`ifdef MUX_SCAN_PARITY_EN
    chk("pat_par0", 32'(bus.out_parity), 32'd0);
`endif
    pop();

    flt_en = 1'b1;
    send(20'hFFFFF);
    wait_done(lat);
    check_res("flt", 20'hFFFFF, 20'hFFFF7, 19, 1'b1);
    pop();
    flt_en = 1'b0;

    send(20'h12345);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 20'hBEEF0;
      end
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_word", 32'(bus.out_word), 32'h12345);
      chk("bp_cnt", 32'(bus.out_count), 32'd7);
    end
    pop();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("bp_data", 32'(mux_data), 32'h12345);

    send(20'hFFFFF);
    n = 0;
    while (mux_addr != AW'(7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_addr7", 32'(mux_addr), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_addr", 32'(mux_addr), 32'd0);
    chk("mid_data", 32'(mux_data), 32'd0);
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_word", 32'(bus.out_word), 32'd0);
    send(20'h00001);
    wait_done(lat);
    check_res("post", 20'h00001, 20'h00001, 1, 1'b0);
    pop();

    sd = 74651;
    hw = DW'($urandom(sd));
    for (int i = 0; i < 10; i++) begin
      w = DW'($urandom);
      send(w);
      wait_done(lat);
      chk("rnd_lat", 32'(lat), 32'd21);
      check_res("rnd", w, w, $countones(w), 1'b0);
      pop();
    end
    if (hw == '0) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
